chacha_qr_engine: RTL and testbench

CHACHA_QR_ENGINE -- requirements
Module: chacha_qr_engine

---
 rtl/chacha_pkg.sv | 13 +
 rtl/chacha_qr_step.sv | 16 +
 rtl/chacha_qr_engine.sv | 111 +++++++++++
 tb/tb_chacha_qr_engine.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// chacha_pkg: shared state/step types and default rotate amounts for the quarter-round engine
package chacha_pkg;
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;
    typedef logic [1:0] step_t;
    localparam int ROT0 = 16;
    localparam int ROT1 = 12;
    localparam int ROT2 = 8;
    localparam int ROT3 = 7;
endpackage

// File: rtl/chacha_qr_step.sv
// chacha_qr_step: one combinational add-xor-rotate step (x+=y; z^=x; z<<<=rot)
module chacha_qr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [6:0]       rot,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] z_out
);
    logic [WIDTH-1:0] t;
    assign x_out = x + y;
    assign t = z ^ x_out;
    assign z_out = (t << rot) | (t >> (7'(WIDTH) - rot));
endmodule

// File: rtl/chacha_qr_engine.sv
// chacha_qr_engine: byte-serial ChaCha quarter-round engine; CHACHA_QR_FEEDFORWARD_EN adds loaded words to the result
module chacha_qr_engine
    import chacha_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int R0    = ROT0,
    parameter int R1    = ROT1,
    parameter int R2    = ROT2,
    parameter int R3    = ROT3,
    parameter int ITER  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);
    localparam int NB = WIDTH / 2;
    localparam int CW = $clog2(NB);
    localparam int W4 = 4 * WIDTH;
`ifdef CHACHA_QR_FEEDFORWARD_EN
    localparam int LAST = 4 * ITER;
`else
    localparam int LAST = 4 * ITER - 1;
`endif

    state_t state;
    logic live;
    logic [CW-1:0] cnt;
    logic [9:0] cyc;
    logic [W4-1:0] st, nxt;
    logic [WIDTH-1:0] a, b, c, d, x, y, z, xn, zn;
    logic [6:0] rot;
    step_t stp;
    logic last_byte, last_cyc;

    assign {d, c, b, a} = st;
    assign stp = cyc[1:0];
    assign last_byte = cnt == CW'(NB - 1);
    assign last_cyc = cyc == 10'(LAST);

    // even steps update a/d, odd steps update c/b
    always_comb begin
        x = stp[0] ? c : a;
        y = stp[0] ? d : b;
        z = stp[0] ? b : d;
        rot = stp == 2'd0 ? 7'(R0) : stp == 2'd1 ? 7'(R1) : stp == 2'd2 ? 7'(R2) : 7'(R3);
        nxt = stp[0] ? {d, xn, zn, a} : {zn, c, b, xn};
    end

    chacha_qr_step #(.WIDTH(WIDTH)) u_step (
        .x     (x),
        .y     (y),
        .z     (z),
        .rot   (rot),
        .x_out (xn),
        .z_out (zn)
    );

`ifdef CHACHA_QR_FEEDFORWARD_EN
    logic [W4-1:0] ini, sum;
    for (genvar i = 0; i < 4; i++) begin : g_ff
        assign sum[i*WIDTH +: WIDTH] = st[i*WIDTH +: WIDTH] + ini[i*WIDTH +: WIDTH];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            live  <= 1'b0;
            cnt   <= '0;
            cyc   <= '0;
            st    <= '0;
`ifdef CHACHA_QR_FEEDFORWARD_EN
            ini   <= '0;
`endif
        end else begin
            live <= 1'b1;
            if (state == LOAD) begin
                if (in_valid && in_ready) begin
                    st[{cnt, 3'b000} +: 8] <= in_data;
`ifdef CHACHA_QR_FEEDFORWARD_EN
                    ini[{cnt, 3'b000} +: 8] <= in_data;
`endif
                    cnt <= last_byte ? '0 : cnt + 1'b1;
                    if (last_byte) state <= COMPUTE;
                end
            end else if (state == COMPUTE) begin
                cyc <= last_cyc ? '0 : cyc + 1'b1;
                if (last_cyc) state <= UNLOAD;
`ifdef CHACHA_QR_FEEDFORWARD_EN
                st <= last_cyc ? sum : nxt;
`else
                st <= nxt;
`endif
            end else if (state == UNLOAD && out_ready) begin
                cnt <= last_byte ? '0 : cnt + 1'b1;
                if (last_byte) state <= LOAD;
            end
        end
    end

    assign in_ready  = live && state == LOAD;
    assign busy      = state == COMPUTE;
    assign out_valid = state == UNLOAD;
    assign out_data  = out_valid ? st[{cnt, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_chacha_qr_engine.sv
// tb_chacha_qr_engine: randomized check of ITER=1 and ITER=2 engines against a word-level quarter-round model
module tb_chacha_qr_engine;
`ifdef CHACHA_QR_FEEDFORWARD_EN
    localparam int FFC = 1;
    localparam logic [127:0] RFC_EXP = {32'h59a50a22, 32'he10eb671, 32'hcc1efbd2, 32'hfb3ba405};
`else
    localparam int FFC = 0;
    localparam logic [127:0] RFC_EXP = {32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4};
`endif
    localparam logic [127:0] RFC_IN = {32'h01234567, 32'h9b8d6f43, 32'h01020304, 32'h11111111};

    logic clk = 1'b0, rst_n = 1'b0, iv = 1'b0, ordy = 1'b0, sel = 1'b0;
    logic [7:0] id = 8'h00;
    logic ir1, ov1, bz1, ir2, ov2, bz2, ir, ov, bz;
    logic [7:0] od1, od2, od;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    chacha_qr_engine #(.ITER(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(id), .in_valid(iv & ~sel), .in_ready(ir1),
        .out_data(od1), .out_valid(ov1), .out_ready(ordy), .busy(bz1)
    );
    chacha_qr_engine #(.ITER(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(id), .in_valid(iv & sel), .in_ready(ir2),
        .out_data(od2), .out_valid(ov2), .out_ready(ordy), .busy(bz2)
    );

    assign ir = sel ? ir2 : ir1;
    assign ov = sel ? ov2 : ov1;
    assign bz = sel ? bz2 : bz1;
    assign od = sel ? od2 : od1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] model(input logic [127:0] v, input int iter);
        logic [31:0] a, b, c, d;
        {d, c, b, a} = v;
        for (int k = 0; k < iter; k++) begin
            a = a + b; d = rotl(d ^ a, 16);
            c = c + d; b = rotl(b ^ c, 12);
            a = a + b; d = rotl(d ^ a, 8);
            c = c + d; b = rotl(b ^ c, 7);
        end
        if (FFC == 1) begin
            a = a + v[31:0]; b = b + v[63:32]; c = c + v[95:64]; d = d + v[127:96];
        end
        return {d, c, b, a};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        if ($urandom_range(3) == 0) begin
            iv = 1'b0;
            @(negedge clk);
        end
        iv = 1'b1;
        id = b;
        while (!ir && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ir) check("tmo_in", {127'd0, ir}, 128'd1);
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic recv(input int mode, input bit spam, input int exp_busy, input string tag,
                        output logic [127:0] res);
        int n = 0, t = 0, nb = 0, ph = 0;
        logic stall = 1'b0;
        logic [7:0] hold = 8'h00;
        res = '0;
        while (n < 16 && t < 2000) begin
            if (spam) begin
                iv = 1'b1;
                id = 8'hff;
            end
            ordy = mode == 0 ? 1'b1 : mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(1));
            if (bz) nb++;
            if (ov) begin
                if (stall) check({tag, "_hold"}, {120'd0, od}, {120'd0, hold});
                if (ordy) begin
                    res[8*n +: 8] = od;
                    n++;
                end
                stall = !ordy;
                hold = od;
                ph++;
            end
            @(negedge clk);
            t++;
        end
        iv = 1'b0;
        ordy = 1'b0;
        if (n < 16) check({tag, "_tmo_out"}, 128'(n), 128'd16);
        check({tag, "_busy_cycles"}, 128'(nb), 128'(exp_busy));
        check({tag, "_back_to_load"}, {126'd0, ir, ov}, 128'd2);
    endtask

    task automatic job(input logic [127:0] v, input int mode, input bit spam, input string tag,
                       output logic [127:0] res);
        int iter = sel ? 2 : 1;
        for (int i = 0; i < 16; i++) send_byte(v[8*i +: 8]);
        check({tag, "_rdy_drop"}, {126'd0, ir, bz}, 128'd1);
        recv(mode, spam, 4 * iter + FFC, tag, res);
        check({tag, "_data"}, res, model(v, iter));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_u1"}, {117'd0, ir1, ov1, bz1, od1}, 128'd0);
        check({tag, "_u2"}, {117'd0, ir2, ov2, bz2, od2}, 128'd0);
    endtask

    initial begin
        logic [127:0] res, v;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        #1 check("rdy_before_edge", {127'd0, ir1}, 128'd0);
        @(negedge clk);
        check("rdy_after_edge", {126'd0, ir1, ir2}, 128'd3);

        job(RFC_IN, 0, 1'b0, "rfc", res);
        check("rfc_const", res, RFC_EXP);
        job(RFC_IN, 1, 1'b0, "rfc_bp", res);
        check("rfc_bp_const", res, RFC_EXP);
        job(RFC_IN, 0, 1'b1, "rfc_spam", res);
        check("rfc_spam_const", res, RFC_EXP);
        v = {$urandom, $urandom, $urandom, $urandom};
        job(v, 2, 1'b0, "after_spam", res);

        for (int i = 0; i < 9; i++) send_byte(8'($urandom));
        rst_n = 1'b0;
        #1 check_reset("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rdy", {127'd0, ir1}, 128'd1);
        job(RFC_IN, 0, 1'b0, "post_abort", res);
        check("post_abort_const", res, RFC_EXP);

        sel = 1'b1;
        job(128'd0, 0, 1'b0, "i2_zero", res);
        check("i2_zero_const", res, 128'd0);
        job(128'd1, 1, 1'b0, "i2_a1", res);
        for (int k = 0; k < 4; k++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            job(v, 2, k[0], "i2_rand", res);
        end

        sel = 1'b0;
        for (int k = 0; k < 6; k++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            job(v, 2, k[0], "i1_rand", res);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
